// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and the instruction memory:
// loader state encoding, frame format, RAM geometry and opcodes.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } loader_state_t;

  // RAM geometry
  localparam int RAM_DEPTH  = 256;
  localparam int RAM_WIDTH  = 8;
  localparam int RAM_ADDR_W = 8;

  // Frame format: a length byte of zero announces a full 256-byte image,
  // and the trailer makes the two's-complement sum of payload + trailer zero.
  localparam logic [7:0] LEN_FULL = 8'd0;
  localparam int         COUNT_W  = 9;

  // Opcodes shared by the instruction memory and loader tests
  localparam logic [7:0] EN0   = 8'h00;
  localparam logic [7:0] EN1   = 8'h01;
  localparam logic [7:0] EN2   = 8'h02;
  localparam logic [7:0] EN3   = 8'h03;
  localparam logic [7:0] LOADA = 8'h04;
  localparam logic [7:0] LOADB = 8'h05;
  localparam logic [7:0] MUL   = 8'h06;
  localparam logic [7:0] ACC   = 8'h07;
  localparam logic [7:0] STORE = 8'h08;
  localparam logic [7:0] INC   = 8'h09;
  localparam logic [7:0] JUMP  = 8'h0A;
  localparam logic [7:0] JUMZ  = 8'h0B;
  localparam logic [7:0] JUMNZ = 8'h0C;

  function automatic logic [COUNT_W-1:0] frame_count(input logic [7:0] len);
    return (len == LEN_FULL) ? COUNT_W'(RAM_DEPTH) : {1'b0, len};
  endfunction

  function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] trailer);
    logic [7:0] total;
    total = sum + trailer;
    return (total == 8'd0);
  endfunction

endpackage

// File: rtl/program_loader.sv
// Parses a length-prefixed, checksummed program frame from a byte stream,
// writes the payload into the instruction RAM and holds the cores until it verifies.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              write_en_file,
  output logic [DATA_W-1:0] instr_file,
  output logic [ADDR_W-1:0] addr_file,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_error
);

  loader_state_t      state_q, state_d;
  logic [COUNT_W-1:0] count_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  sum_q;
  logic               xfer;

  assign xfer = rx_valid & rx_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_LEN;
      ST_LEN:  if (xfer) state_d = ST_DATA;
      ST_DATA: if (xfer && count_q == COUNT_W'(1)) state_d = ST_CSUM;
      ST_CSUM: if (xfer) state_d = csum_ok(sum_q, rx_data) ? ST_DONE : ST_ERROR;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are pure functions of the state, so they settle one
  // cycle after the transfer that moved the FSM.
  always_comb begin
    rx_ready   = 1'b0;
    core_hold  = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    unique case (state_q)
      ST_LEN, ST_DATA, ST_CSUM: rx_ready = 1'b1;
      ST_DONE: begin
        core_hold = 1'b0;
        load_done = 1'b1;
      end
      ST_ERROR: load_error = 1'b1;
      default: ;
    endcase
  end

  // Datapath: the write strobe defaults low every cycle so a single payload
  // transfer yields exactly one strobe, and reset cancels a pending one.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q       <= '0;
      addr_q        <= BASE_ADDR;
      sum_q         <= '0;
      write_en_file <= 1'b0;
      instr_file    <= '0;
      addr_file     <= '0;
    end else begin
      write_en_file <= 1'b0;
      unique case (state_q)
        ST_LEN: if (xfer) begin
          count_q <= frame_count(rx_data);
          addr_q  <= BASE_ADDR;
          sum_q   <= '0;
        end
        ST_DATA: if (xfer) begin
          write_en_file <= 1'b1;
          instr_file    <= rx_data;
          addr_file     <= addr_q;
          addr_q        <= addr_q + 1'b1;
          sum_q         <= sum_q + rx_data;
          count_q       <= count_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
